// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit bus: imem port, redirect input, decode handshake, status
interface instruction_fetch_unit_if #(
  parameter int QUEUE_DEPTH = 4
);
  logic [63:0]                    imem_addr;
  logic [31:0]                    imem_data;
  logic                           redirect_valid;
  logic [63:0]                    redirect_pc;
  logic                           out_valid;
  logic                           out_ready;
  logic [31:0]                    out_instr;
  logic [63:0]                    out_pc;
  logic [$clog2(QUEUE_DEPTH):0]   queue_count;
  logic                           misaligned_trap;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, queue_count, misaligned_trap,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, queue_count, misaligned_trap,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, imem fetch, instruction queue to decode, redirect/halt
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instruction_fetch_unit_if.master bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  logic [63:0]   pc_q, pc_d;
  logic [0:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          trap_q, trap_d;
  logic [63:0]   pc_mem_q    [QUEUE_DEPTH];
  logic [31:0]   instr_mem_q [QUEUE_DEPTH];

  logic fetching, redirect, misaligned, pop, push, head_valid;

  assign head_valid = (count_q != '0);
  assign fetching   = (state_q == ST_FETCH);
  assign redirect   = fetching & bus.redirect_valid;
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
  assign pop        = head_valid & bus.out_ready;
  assign push       = fetching & ~bus.redirect_valid & ((count_q < DEPTH_C) | pop);

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    trap_d   = trap_q;
    if (redirect) begin
      // Flush drops the head too; a same-cycle pop is simply absorbed.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (misaligned) begin
        trap_d  = 1'b1;
        state_d = ST_HALT;
      end else begin
        pc_d = bus.redirect_pc;
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + 64'd4;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_FETCH;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      trap_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      trap_q   <= trap_d;
    end
  end

  // Entry storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_data;
    end
  end

  assign bus.imem_addr       = {2'b00, pc_q[63:2]};
  assign bus.out_valid       = head_valid;
  assign bus.out_instr       = head_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign bus.out_pc          = head_valid ? pc_mem_q[rd_ptr_q] : 64'd0;
  assign bus.queue_count     = count_q;
  assign bus.misaligned_trap = trap_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized bench for instruction_fetch_unit against a queue model
module tb_instruction_fetch_unit;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic rst2_n;
  int   n_cmp;
  int   n_bad;

  instruction_fetch_unit_if #(.QUEUE_DEPTH(DEPTH)) bus ();
  instruction_fetch_unit_if #(.QUEUE_DEPTH(DEPTH)) bus2 ();

  instruction_fetch_unit #(.RESET_PC(64'd0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QUEUE_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.master)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0100_0093;
  endfunction

  assign bus.imem_data  = mem_word(bus.imem_addr);
  assign bus2.imem_data = mem_word(bus2.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: byte PC, queue of {pc, instr}, halt/trap flags
  logic [63:0] m_pc;
  logic [95:0] m_q[$];
  bit          m_halt;
  bit          m_trap;

  function automatic logic [63:0] m_head_pc();
    return (m_q.size() != 0) ? m_q[0][95:32] : 64'd0;
  endfunction

  function automatic logic [31:0] m_head_instr();
    return (m_q.size() != 0) ? m_q[0][31:0] : 32'd0;
  endfunction

  task automatic step(input bit rv, input logic [63:0] rpc, input bit rdy);
    int sz;
    bit pop, push_ok;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    sz      = m_q.size();
    pop     = (sz != 0) && rdy;
    push_ok = !m_halt && !rv && ((sz < DEPTH) || pop);
    if (!m_halt && rv) begin
      m_q.delete();
      if (rpc[1:0] == 2'b00) m_pc = rpc;
      else begin
        m_halt = 1'b1;
        m_trap = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push_ok) begin
        m_q.push_back({m_pc, mem_word({2'b00, m_pc[63:2]})});
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_assert();
    #2;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    m_q.delete();
    m_pc   = 64'd0;
    m_halt = 1'b0;
    m_trap = 1'b0;
    #1;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.queue_count !== 3'd0 || bus.out_pc !== 64'd0 ||
        bus.out_instr !== 32'd0 || bus.misaligned_trap !== 1'b0 || bus.imem_addr !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%0b count=%0d pc=%h instr=%h trap=%0b addr=%h, want all zero",
               bus.out_valid, bus.queue_count, bus.out_pc, bus.out_instr, bus.misaligned_trap, bus.imem_addr);
    end
    reset_release();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.imem_addr !== 64'(i)) begin
        n_bad++;
        $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.imem_addr, 64'(i));
      end
      step(1'b0, 64'd0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * i) || bus.out_instr !== m_head_instr()) begin
        n_bad++;
        $display("FAIL stream_head[%0d]: valid=%0b pc=%h instr=%h want pc=%h instr=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, 64'(4 * i), m_head_instr());
      end
    end
  endtask

  task automatic test_backpressure();
    int next_pc;
    reset_assert();
    reset_release();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 64'd0, 1'b0);
      n_cmp++;
      if (bus.queue_count !== 3'((i < 4) ? i + 1 : 4)) begin
        n_bad++;
        $display("FAIL bp_count[%0d]: got %0d want %0d", i, bus.queue_count, (i < 4) ? i + 1 : 4);
      end
    end
    n_cmp++;
    if (bus.imem_addr !== 64'd4) begin
      n_bad++;
      $display("FAIL bp_pc_stop: imem_addr %h want 4", bus.imem_addr);
    end
    next_pc = 0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(next_pc)) begin
        n_bad++;
        $display("FAIL bp_drain[%0d]: valid=%0b pc=%h want pc=%h", i, bus.out_valid, bus.out_pc, 64'(next_pc));
      end
      next_pc += 4;
      step(1'b0, 64'd0, 1'b1);
      if (i == 0) begin
        n_cmp++;
        if (bus.queue_count !== 3'd4 || bus.imem_addr !== 64'd5) begin
          n_bad++;
          $display("FAIL full_pop: count=%0d addr=%h want count=4 addr=5", bus.queue_count, bus.imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    reset_assert();
    reset_release();
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b0);
    n_cmp++;
    if (bus.queue_count !== 3'd3) begin
      n_bad++;
      $display("FAIL redir_pre_count: got %0d want 3", bus.queue_count);
    end
    step(1'b1, 64'd960, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.queue_count !== 3'd0 || bus.imem_addr !== 64'd240) begin
      n_bad++;
      $display("FAIL redir_flush: valid=%0b count=%0d addr=%h want 0/0/240",
               bus.out_valid, bus.queue_count, bus.imem_addr);
    end
    step(1'b0, 64'd0, 1'b0);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'd960 || bus.out_instr !== mem_word(64'd240)) begin
      n_bad++;
      $display("FAIL redir_target: valid=%0b pc=%h instr=%h want pc=3c0 instr=%h",
               bus.out_valid, bus.out_pc, bus.out_instr, mem_word(64'd240));
    end
  endtask

  task automatic test_random();
    bit          rv, rdy;
    logic [63:0] rpc;
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      rpc[1:0] = 2'b00;
      step(rv, rpc, rdy);
      n_cmp++;
      if (bus.out_valid !== (m_q.size() != 0) || bus.queue_count !== 3'(m_q.size()) ||
          bus.out_pc !== m_head_pc() || bus.out_instr !== m_head_instr() ||
          bus.imem_addr !== {2'b00, m_pc[63:2]} || bus.misaligned_trap !== 1'b0) begin
        n_bad++;
        $display("FAIL rand[%0d]: valid=%0b cnt=%0d pc=%h instr=%h addr=%h want cnt=%0d pc=%h instr=%h addr=%h",
                 i, bus.out_valid, bus.queue_count, bus.out_pc, bus.out_instr, bus.imem_addr,
                 m_q.size(), m_head_pc(), m_head_instr(), {2'b00, m_pc[63:2]});
      end
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] frozen;
    step(1'b0, 64'd0, 1'b0);
    step(1'b0, 64'd0, 1'b0);
    frozen = {2'b00, m_pc[63:2]};
    step(1'b1, 64'h102, 1'b1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (bus.misaligned_trap !== 1'b1 || bus.out_valid !== 1'b0 || bus.queue_count !== 3'd0 ||
          bus.imem_addr !== frozen) begin
        n_bad++;
        $display("FAIL halt[%0d]: trap=%0b valid=%0b cnt=%0d addr=%h want 1/0/0/%h",
                 i, bus.misaligned_trap, bus.out_valid, bus.queue_count, bus.imem_addr, frozen);
      end
      step(i[0], 64'h400, 1'b1);
    end
    reset_assert();
    n_cmp++;
    if (bus.misaligned_trap !== 1'b0 || bus.imem_addr !== 64'd0) begin
      n_bad++;
      $display("FAIL halt_reset: trap=%0b addr=%h want 0/0", bus.misaligned_trap, bus.imem_addr);
    end
    reset_release();
    step(1'b0, 64'd0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'd0) begin
      n_bad++;
      $display("FAIL halt_restart: valid=%0b pc=%h want 1/0", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b0);
    reset_assert();
    n_cmp++;
    if (bus.queue_count !== 3'd0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 64'd0) begin
      n_bad++;
      $display("FAIL mid_reset: cnt=%0d valid=%0b addr=%h want 0/0/0", bus.queue_count, bus.out_valid, bus.imem_addr);
    end
    reset_release();
  endtask

  task automatic test_wrap();
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 64'd0;
    bus2.out_ready      = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus2.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus2.out_valid !== 1'b1 || bus2.imem_addr !== 64'd0) begin
      n_bad++;
      $display("FAIL wrap_first: valid=%0b pc=%h addr=%h want 1/fffffffffffffffc/0",
               bus2.out_valid, bus2.out_pc, bus2.imem_addr);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus2.out_pc !== 64'd0 || bus2.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_second: valid=%0b pc=%h want 1/0", bus2.out_valid, bus2.out_pc);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 64'd0;
    bus.out_ready       = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 64'd0;
    bus2.out_ready      = 1'b0;
    m_q.delete();
    m_pc   = 64'd0;
    m_halt = 1'b0;
    m_trap = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_random();
    test_misaligned();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
